inv_key_expansion: RTL and testbench
====================================

INV_KEY_EXPANSION -- requirements
Module: inv_key_expansion

Interface
REQ-001 The module SHALL have a single clock `clk`; reset `rst` SHALL be synchronous and active-high.
REQ-002 Port `clk`, input, 1 bit: rising-edge clock.
REQ-003 Port `rst`, input, 1 bit: synchronous active-high reset.
REQ-004 Port `start`, input, 1 bit: load the cipher key and begin; sampled only in IDLE.
REQ-005 Port `key`, input, [0:127]: AES-128 cipher key; byte 0 is key[0:7]; sampled with `start`.
REQ-006 Port `next`, input, 1 bit: consumer request to step to the previous round key; sampled only while `key_valid`=1.
REQ-007 Port `round_key`, output, [0:127]: current round key, registered; word order w0=[0:31] .. w3=[96:127].
REQ-008 Port `round_idx`, output, 4 bits: AES round number (0..10) of `round_key`.
REQ-009 Port `key_valid`, output, 1 bit: `round_key` and `round_idx` are valid.
REQ-010 Port `busy`, output, 1 bit: high in every state except IDLE.
REQ-011 Port `done`, output, 1 bit: one-cycle pulse after round key 0 is consumed.

Function
REQ-012 The FSM SHALL have three states: IDLE, FWD and SERVE.
REQ-013 IDLE with `start`=1: register `key` into the key register, set the round counter to 0 and go to FWD.
REQ-014 FWD: each cycle apply one FIPS-197 forward step with Rcon(counter+1), then increment the counter; after the step producing round 10, go to SERVE.
REQ-015 Forward step: t = SubWord(RotWord(w3)) ^ Rcon; w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
REQ-016 Rcon(1..10) SHALL be 01,02,04,08,10,20,40,80,1B,36 in the most significant byte.
REQ-017 `key_valid` SHALL rise exactly 11 clock edges after the edge that sampled `start`, with `round_idx`=10.
REQ-018 SERVE with `next`=1 and `round_idx`=r>0: apply the inverse step with Rcon(r), so `round_key` and `round_idx`=r-1 update on the same edge (latency 1) and `key_valid` stays high.
REQ-019 Inverse step: w3' = w3^w2; w2' = w2^w1; w1' = w1^w0; w0' = w0 ^ SubWord(RotWord(w3')) ^ Rcon(r).
REQ-020 SERVE with `next`=0: `round_key` and `round_idx` SHALL hold indefinitely.
REQ-021 SERVE with `next`=1 and `round_idx`=0: go to IDLE, deassert `key_valid`, and pulse `done` for exactly one cycle.
REQ-022 `start` outside IDLE SHALL be ignored; `start` and `done` in the same cycle SHALL NOT start a new run.
REQ-023 `next` outside SERVE SHALL be ignored.
REQ-024 `round_key` SHALL retain its last value in IDLE; it is meaningful only when `key_valid`=1.
REQ-025 Back-to-back `next` on consecutive cycles SHALL step one round per cycle with no bubbles.

Reset
REQ-026 With `rst`=1 at an edge: state=IDLE, `round_key`=0, `round_idx`=0, `key_valid`=0, `busy`=0, `done`=0, counter=0.
REQ-027 Reset SHALL take priority over `start` and `next` and SHALL abort any FWD or SERVE run with no residual output.

Structure
REQ-028 The S-box table, the Rcon table and the FSM state encoding SHALL live in a shared AES package used by both the forward and the inverse key units.
REQ-029 The four-byte SubWord SHALL be a sub-module `aes_sub_word` (32-bit in, 32-bit out, combinational), instantiated once and muxed between the FWD and SERVE datapaths.
REQ-030 The implementation SHALL contain no per-round key storage; only the single 128-bit key register is permitted.

Verification
REQ-031 Apply `start` with key 2b7e151628aed2a6abf7158809cf4f3c -> 11 cycles later `key_valid`=1, `round_idx`=10, `round_key`=d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-032 From REQ-031, hold `next` high continuously -> round 9 = ac7766f319fadc2128d12941575c006e, ..., round 1 = a0fafe1788542cb123a339392a6c7605, round 0 = 2b7e1516...; `done` pulses once on the following cycle.
REQ-033 Hold `next` low for 50 cycles at round 5, then pulse it -> the key is unchanged during the hold, and round 4 appears one cycle after the pulse.
REQ-034 Pulse `start` during FWD and during SERVE with a different key -> no effect; the key sequence matches the first key.
REQ-035 Assert `rst` during FWD cycle 6 and again at round 3 -> all outputs are 0 on the next cycle; a fresh `start` then reproduces REQ-031.
REQ-036 Run the all-zero key and the all-FF key, and compare all 11 round keys against the reference model -> exact match, with `done` asserted exactly once per run.

Source files
------------

// File: rtl/inv_key_expansion_pkg.sv
// Shared AES key-schedule definitions: S-box, round constants, FSM encoding, word helpers.
// Purely declarative; no latency or flow control of its own.
package inv_key_expansion_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FWD   = 2'd1,
        ST_SERVE = 2'd2
    } state_t;

    localparam int unsigned LAST_ROUND = 10;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Round constant for rounds 1..10, placed later in the word's top byte.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Four parallel S-box lookups on a 32-bit word.
// Purely combinational: zero latency, no flow control.
module aes_sub_word
    import inv_key_expansion_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] subbed
);

    always_comb begin
        subbed = {SBOX[word[31:24]], SBOX[word[23:16]], SBOX[word[15:8]], SBOX[word[7:0]]};
    end

endmodule

// File: rtl/inv_key_expansion.sv
// AES-128 round keys served in reverse order (10 down to 0) from a single 128-bit register.
// Round 10 is ready 11 cycles after start; each next steps one round per cycle, holding while next is low.
module inv_key_expansion
    import inv_key_expansion_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [0:127] key,
    input  logic         next,
    output logic [0:127] round_key,
    output logic [3:0]   round_idx,
    output logic         key_valid,
    output logic         busy,
    output logic         done
);

    state_t       state;
    state_t       state_nxt;
    logic [0:127] key_nxt;
    logic [3:0]   idx_nxt;
    logic         valid_nxt;
    logic         done_nxt;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] sub_in, sub_out;
    logic [31:0] fwd_t, f0, f1, f2, f3;
    logic [31:0] inv_w3, inv_w0;
    logic [0:127] fwd_key, inv_key;

    assign w0 = round_key[0:31];
    assign w1 = round_key[32:63];
    assign w2 = round_key[64:95];
    assign w3 = round_key[96:127];

    // The inverse step substitutes the *recovered* w3, so the shared S-box input differs by state.
    assign inv_w3 = w3 ^ w2;
    assign sub_in = (state == ST_SERVE) ? rot_word(inv_w3) : rot_word(w3);

    aes_sub_word u_sub_word (
        .word   (sub_in),
        .subbed (sub_out)
    );

    assign fwd_t   = sub_out ^ {rcon(4'(round_idx + 4'd1)), 24'h0};
    assign f0      = w0 ^ fwd_t;
    assign f1      = w1 ^ f0;
    assign f2      = w2 ^ f1;
    assign f3      = w3 ^ f2;
    assign fwd_key = {f0, f1, f2, f3};

    assign inv_w0  = w0 ^ sub_out ^ {rcon(round_idx), 24'h0};
    assign inv_key = {inv_w0, w1 ^ w0, w2 ^ w1, inv_w3};

    assign busy = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        key_nxt   = round_key;
        idx_nxt   = round_idx;
        valid_nxt = key_valid;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                // A start coinciding with the done pulse belongs to the finished run.
                if (start && !done) begin
                    key_nxt   = key;
                    idx_nxt   = 4'd0;
                    state_nxt = ST_FWD;
                end
            end
            ST_FWD: begin
                key_nxt = fwd_key;
                idx_nxt = 4'(round_idx + 4'd1);
                if (round_idx == 4'(LAST_ROUND - 1)) begin
                    state_nxt = ST_SERVE;
                end
            end
            ST_SERVE: begin
                // First SERVE cycle only raises key_valid, giving the 11-cycle start-to-valid latency.
                if (!key_valid) begin
                    valid_nxt = 1'b1;
                end else if (next) begin
                    if (round_idx == 4'd0) begin
                        state_nxt = ST_IDLE;
                        valid_nxt = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        key_nxt = inv_key;
                        idx_nxt = 4'(round_idx - 4'd1);
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            round_key <= '0;
            round_idx <= 4'd0;
            key_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            round_key <= key_nxt;
            round_idx <= idx_nxt;
            key_valid <= valid_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_inv_key_expansion.sv
// Directed/random bench: round keys checked against a word-array FIPS-197 expansion with an S-box derived from GF(2^8).
module tb_inv_key_expansion;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key;
    logic         next;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         key_valid;
    logic         busy;
    logic         done;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;

    logic [7:0]   sbox_m [256];
    logic [127:0] rk [0:10];

    localparam logic [127:0] KAT_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KAT_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KAT_R9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] KAT_R1  = 128'ha0fafe1788542cb123a339392a6c7605;

    inv_key_expansion dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key       (key),
        .next      (next),
        .round_key (round_key),
        .round_idx (round_idx),
        .key_valid (key_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_m(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    // Textbook 44-word expansion; rk[r] is the key of round r.
    task automatic expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] temp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = sub_m({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".round_key"}, round_key, 128'h0);
        check({tag, ".round_idx"}, 128'(round_idx), 128'h0);
        check({tag, ".flags"}, {125'h0, key_valid, busy, done}, 128'h0);
    endtask

    // Load k and run the forward phase; optionally glitch start mid-FWD or reset at FWD cycle abort_at.
    task automatic start_run(input logic [127:0] k, input int abort_at, input bit glitch);
        done_cnt = 0;
        key = k; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            if (glitch && i == 4) begin key = ~k; start = 1'b1; end
            if (i == abort_at) rst = 1'b1;
            tick();
            start = 1'b0;
            if (i == abort_at) begin
                rst = 1'b0;
                check_zero("rst_in_fwd");
                return;
            end
            if (i == 10) check("valid_early", {126'h0, key_valid, busy}, 128'h1);
        end
        check("valid_at_11", {126'h0, key_valid, busy}, 128'h3);
        check("idx_at_11", 128'(round_idx), 128'd10);
        check("rk10", round_key, rk[10]);
    endtask

    // Step from round from_r down to to_r; to_r==0 also consumes round 0 and checks done handling.
    task automatic serve(input int from_r, input int to_r, input int max_gap, input int hold_r, input bit kat);
        int gap;
        for (int r = from_r; r > to_r; r--) begin
            gap = (r == hold_r) ? 50 : int'($urandom_range(0, max_gap));
            if (gap > 0) begin
                next = 1'b0;
                repeat (gap) tick();
                check("hold_key", round_key, rk[r]);
                check("hold_idx", 128'(round_idx), 128'(r));
            end
            next = 1'b1;
            tick();
            check("step_key", round_key, rk[r-1]);
            check("step_idx_valid", {123'h0, round_idx, key_valid}, {123'h0, 4'(r-1), 1'b1});
            if (kat && r-1 == 9) check("kat_r9", round_key, KAT_R9);
            if (kat && r-1 == 1) check("kat_r1", round_key, KAT_R1);
            if (kat && r-1 == 0) check("kat_r0", round_key, KAT_KEY);
        end
        if (to_r == 0) begin
            next = 1'b1;
            tick();
            check("done_pulse", {125'h0, key_valid, busy, done}, 128'h1);
            key = {$urandom, $urandom, $urandom, $urandom};
            start = 1'b1; next = 1'b0;
            tick();
            start = 1'b0;
            check("start_with_done", {125'h0, key_valid, busy, done}, 128'h0);
            tick();
            check("done_once", 128'(done_cnt), 128'd1);
        end
        next = 1'b0;
    endtask

    initial begin
        logic [127:0] k;
        rst = 1'b1; start = 1'b0; next = 1'b0; key = '0;
        build_sbox();
        repeat (2) tick();
        check_zero("reset");
        rst = 1'b0;
        tick();
        check_zero("idle_after_reset");

        // Known vector, start glitched during FWD, back-to-back next.
        expand(KAT_KEY);
        start_run(KAT_KEY, 0, 1'b1);
        check("kat_r10", round_key, KAT_R10);
        serve(10, 0, 0, -1, 1'b1);

        // Random key: start ignored in SERVE, 50-cycle hold at round 5.
        k = {$urandom, $urandom, $urandom, $urandom};
        expand(k);
        start_run(k, 0, 1'b0);
        key = ~k; start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_serve", round_key, rk[10]);
        serve(10, 0, 0, 5, 1'b0);

        // Reset during FWD cycle 6 and at round 3, each followed by a fresh run.
        expand(KAT_KEY);
        start_run(KAT_KEY, 6, 1'b0);
        start_run(KAT_KEY, 0, 1'b0);
        serve(10, 3, 0, -1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("rst_in_serve");
        start_run(KAT_KEY, 0, 1'b0);
        check("kat_r10_again", round_key, KAT_R10);
        serve(10, 0, 1, -1, 1'b1);

        // Corner keys, then random keys with random next gaps.
        expand(128'h0);
        start_run(128'h0, 0, 1'b0);
        serve(10, 0, 0, -1, 1'b0);
        expand({128{1'b1}});
        start_run({128{1'b1}}, 0, 1'b0);
        serve(10, 0, 0, -1, 1'b0);
        for (int n = 0; n < 4; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            expand(k);
            start_run(k, 0, 1'b0);
            serve(10, 0, 3, -1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
